pattern_detector: RTL and testbench

Serial pattern detector that sits directly upstream of the controller FSM and produces its `match_flag` and `halt_flag` inputs. A qualified serial bit stream is shifted into a WIDTH-bit window and compared against a loadable pattern. Matches are counted, with overlapping matches allowed. A sticky halt is raised when the match budget is exhausted or when halt is requested externally.

---
 rtl/pattern_detector_pkg.sv | 13 +
 rtl/pd_window.sv | 37 +++
 rtl/pattern_detector.sv | 129 ++++++++++++
 tb/tb_pattern_detector.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_detector_pkg.sv
// Shared state encoding and default sizing for the serial pattern detector.
package pattern_detector_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam int PD_WIDTH     = 8;
  localparam int PD_MAX_MATCH = 15;

endpackage

// File: rtl/pd_window.sv
// WIDTH-bit serial window: newest bit enters the LSB, clear wins over shift.
// The candidate is the window as it would look after shifting bit_i in.
module pd_window
  import pattern_detector_pkg::*;
#(
  parameter int WIDTH = PD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] cand_o
);

  logic [WIDTH-1:0] win_q, win_d;

  assign cand_o = {win_q[WIDTH-2:0], bit_i};

  always_comb begin
    win_d = win_q;
    if (clr_i) begin
      win_d = '0;
    end else if (shift_i) begin
      win_d = cand_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector: fills a window, counts overlapping matches and raises
// a sticky halt on match budget exhaustion or external request.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter  int WIDTH     = PD_WIDTH,
  parameter  int MAX_MATCH = PD_MAX_MATCH,
  localparam int CNT_W     = $clog2(MAX_MATCH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_pattern,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             data_valid,
  input  logic             data_in,
  input  logic             halt_req,
  output logic             match_flag,
  output logic             halt_flag,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int               FILL_W    = $clog2(WIDTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_MATCH);

  state_e             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [WIDTH-1:0]   pattern_q, pattern_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d;
  logic               halt_q, halt_d;
  logic               armed_q, armed_d;
  logic               win_clr, win_shift, cmp;
  logic [WIDTH-1:0]   cand;

  pd_window #(.WIDTH(WIDTH)) u_window (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (win_clr),
    .shift_i (win_shift),
    .bit_i   (data_in),
    .cand_o  (cand)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    halt_d    = halt_q;
    win_clr   = 1'b0;
    win_shift = 1'b0;
    cmp       = 1'b0;

    case (state_q)
      ST_FILL, ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALTED;
          halt_d  = 1'b1;
          match_d = 1'b0;
        end else if (load_pattern) begin
          pattern_d = pattern_in;
          win_clr   = 1'b1;
          fill_d    = '0;
          match_d   = 1'b0;
          state_d   = ST_FILL;
        end else if (data_valid) begin
          win_shift = 1'b1;
          if (state_q == ST_RUN) begin
            cmp = 1'b1;
          end else if (fill_q == FILL_LAST) begin
            cmp     = 1'b1;
            state_d = ST_RUN;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
      end
      default: begin
        // HALTED and any illegal encoding behave as a locked halt.
        state_d = ST_HALTED;
        halt_d  = 1'b1;
        match_d = 1'b0;
      end
    endcase

    if (cmp) begin
      match_d = (cand == pattern_q);
      if (match_d && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_MAX) begin
          state_d = ST_HALTED;
          halt_d  = 1'b1;
          match_d = 1'b0;
        end
      end
    end
  end

  assign armed_d = (state_d == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FILL;
      fill_q    <= '0;
      pattern_q <= '0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      halt_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      halt_q    <= halt_d;
      armed_q   <= armed_d;
    end
  end

  assign match_flag  = match_q;
  assign halt_flag   = halt_q;
  assign match_count = cnt_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector (WIDTH=4, MAX_MATCH=3): directed
// scenarios against hand-derived values plus random traffic against a queue model.
module tb_pattern_detector;

  localparam int W = 4;
  localparam int M = 3;
  localparam logic [W-1:0] P = 4'b1011;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_pattern = 1'b0;
  logic [W-1:0] pattern_in = '0;
  logic         data_valid = 1'b0;
  logic         data_in = 1'b0;
  logic         halt_req = 1'b0;
  logic         match_flag, halt_flag, armed;
  logic [1:0]   match_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_detector #(.WIDTH(W), .MAX_MATCH(M)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_pattern (load_pattern),
    .pattern_in   (pattern_in),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .halt_req     (halt_req),
    .match_flag   (match_flag),
    .halt_flag    (halt_flag),
    .match_count  (match_count),
    .armed        (armed)
  );

  // {match_flag, halt_flag, armed, match_count}
  wire [4:0] obs = {match_flag, halt_flag, armed, match_count};

  // Reference model: bits since the last load/reset kept in a queue.
  logic [W-1:0] m_pat;
  bit           m_q[$];
  int           m_cnt;
  bit           m_halt, m_match;

  function automatic void model_reset();
    m_pat = '0;
    m_q.delete();
    m_cnt = 0;
    m_halt = 1'b0;
    m_match = 1'b0;
  endfunction

  function automatic void model_step(input logic hr, input logic ld, input logic [W-1:0] pin,
                                     input logic dv, input logic din);
    logic [W-1:0] win;
    if (m_halt) return;
    if (hr) begin
      m_halt = 1'b1;
      m_match = 1'b0;
    end else if (ld) begin
      m_pat = pin;
      m_q.delete();
      m_match = 1'b0;
    end else if (dv) begin
      m_q.push_back(din);
      if (m_q.size() > W) void'(m_q.pop_front());
      if (m_q.size() == W) begin
        win = '0;
        foreach (m_q[i]) win = {win[W-2:0], m_q[i]};
        m_match = (win == m_pat);
        if (m_match) begin
          m_cnt++;
          if (m_cnt >= M) begin
            m_cnt = M;
            m_halt = 1'b1;
            m_match = 1'b0;
          end
        end
      end
    end
  endfunction

  function automatic logic [4:0] model_vec();
    logic a;
    a = !m_halt && (m_q.size() == W);
    return {m_match, m_halt, a, 2'(m_cnt)};
  endfunction

  task automatic drive(input logic hr, input logic ld, input logic [W-1:0] pin,
                       input logic dv, input logic din);
    @(negedge clk);
    halt_req = hr;
    load_pattern = ld;
    pattern_in = pin;
    data_valid = dv;
    data_in = din;
    @(posedge clk);
    model_step(hr, ld, pin, dv, din);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    halt_req = 1'b0;
    load_pattern = 1'b0;
    data_valid = 1'b0;
    data_in = 1'b0;
    pattern_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL reset_state got=%b exp=%b", obs, 5'b00000);
    end
    drive(0, 1, P, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, P, 1, 1);
      checks++;
      if (obs !== 5'b00000) begin
        errors++; $display("FAIL reset_fill bit%0d got=%b exp=%b", i, obs, 5'b00000);
      end
    end
    drive(0, 0, P, 1, 1);
    checks++;
    if (obs !== 5'b00100) begin
      errors++; $display("FAIL reset_armed got=%b exp=%b", obs, 5'b00100);
    end
  endtask

  task automatic test_basic();
    logic [3:0] seq;
    seq = 4'b1011;
    do_reset();
    drive(0, 1, P, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, P, 1, seq[3-i]);
      checks++;
      if (obs !== ((i == 3) ? 5'b10101 : 5'b00000)) begin
        errors++; $display("FAIL basic_bit%0d got=%b", i, obs);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, P, 0, 0);
      checks++;
      if (obs !== 5'b10101) begin
        errors++; $display("FAIL basic_gap_hold got=%b exp=%b", obs, 5'b10101);
      end
    end
    drive(0, 0, P, 1, 0);
    checks++;
    if (obs !== 5'b00101) begin
      errors++; $display("FAIL basic_nomatch got=%b exp=%b", obs, 5'b00101);
    end
    drive(0, 0, P, 0, 1);
    checks++;
    if (obs !== 5'b00101) begin
      errors++; $display("FAIL basic_gap_low got=%b exp=%b", obs, 5'b00101);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] seq, expm;
    seq  = 7'b1011011;
    expm = 7'b0001001;
    do_reset();
    drive(0, 1, P, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, P, 1, seq[6-i]);
      checks++;
      if (match_flag !== expm[6-i]) begin
        errors++; $display("FAIL overlap_bit%0d got=%b exp=%b", i, match_flag, expm[6-i]);
      end
    end
    checks++;
    if (obs !== 5'b10110) begin
      errors++; $display("FAIL overlap_count got=%b exp=%b", obs, 5'b10110);
    end
  endtask

  task automatic test_reload();
    logic [3:0] seq;
    seq = 4'b1011;
    do_reset();
    drive(0, 1, P, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, P, 1, seq[3-i]);
    drive(0, 1, P, 1, 1);
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL reload_load got=%b exp=%b", obs, 5'b00000);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, P, 1, seq[3-i]);
      checks++;
      if (obs !== ((i == 3) ? 5'b10101 : 5'b00000)) begin
        errors++; $display("FAIL reload_bit%0d got=%b", i, obs);
      end
    end
  endtask

  task automatic test_budget();
    logic [9:0] seq;
    logic [3:0] more;
    seq  = 10'b1011011011;
    more = 4'b1011;
    do_reset();
    drive(0, 1, P, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, P, 1, seq[9-i]);
      if (i == 3 || i == 6 || i == 9) begin
        checks++;
        if (obs !== ((i == 3) ? 5'b10101 : (i == 6) ? 5'b10110 : 5'b01011)) begin
          errors++; $display("FAIL budget_bit%0d got=%b", i, obs);
        end
      end
    end
    drive(0, 1, 4'b0000, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, P, 1, more[3-i]);
      checks++;
      if (obs !== 5'b01011) begin
        errors++; $display("FAIL budget_frozen%0d got=%b exp=%b", i, obs, 5'b01011);
      end
    end
    do_reset();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL budget_reset got=%b exp=%b", obs, 5'b00000);
    end
  endtask

  task automatic test_halt_priority();
    logic [5:0] seq;
    seq = 6'b101101;
    do_reset();
    drive(0, 1, P, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, P, 1, seq[5-i]);
    checks++;
    if (obs !== 5'b00101) begin
      errors++; $display("FAIL prio_setup got=%b exp=%b", obs, 5'b00101);
    end
    drive(1, 1, 4'b0000, 1, 1);
    checks++;
    if (obs !== 5'b01001) begin
      errors++; $display("FAIL prio_halt got=%b exp=%b", obs, 5'b01001);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL async_reset got=%b exp=%b", obs, 5'b00000);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic hr, ld, dv, din;
    logic [W-1:0] pin;
    for (int s = 0; s < 20; s++) begin
      do_reset();
      drive(0, 1, W'($urandom), 0, 0);
      for (int c = 0; c < 60; c++) begin
        hr  = ($urandom_range(0, 63) == 0);
        ld  = ($urandom_range(0, 31) == 0);
        pin = W'($urandom);
        dv  = ($urandom_range(0, 3) != 0);
        din = 1'($urandom);
        drive(hr, ld, pin, dv, din);
        checks++;
        if (obs !== model_vec()) begin
          errors++; $display("FAIL random seg%0d cyc%0d got=%b exp=%b", s, c, obs, model_vec());
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overlap();
    test_reload();
    test_budget();
    test_halt_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
